// File: rtl/alu_mdu.sv
// alu_mdu: RV32I register/immediate ALU plus RV32M multiply/divide unit.
// Base ops finish in one cycle. M ops use an iterative shift-add multiplier
// and a restoring divider at one bit per cycle, so every M op has a fixed
// latency of WIDTH+1 edges, including divide-by-zero and signed overflow.
//
// Ports:
//   clk_i    in   1      clock, rising edge
//   rst_i    in   1      synchronous active-high reset
//   start_i  in   1      request valid, sampled only while busy_o=0
//   opr_1    in   WIDTH  rs1 operand
//   opr_2    in   WIDTH  rs2 / immediate operand
//   alu_op   in   4      {m_sel, funct3}
//   flag     in   1      SUB / SRA select
//   result_o out  WIDTH  registered result, held until the next completion
//   valid_o  out  1      one-cycle pulse when result_o is new
//   busy_o   out  1      M op in flight
module alu_mdu #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] opr_1,
    input  logic [WIDTH-1:0] opr_2,
    input  logic [3:0]       alu_op,
    input  logic             flag,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Two's complement negation at operand width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's complement negation at double (product) width.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        neg_2w = (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic [2:0]         op_r;
    logic               neg_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   b_mag_r;
    // Shared accumulator: {product high, multiplier} for multiply,
    // {partial remainder, dividend/quotient} for divide.
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   result_r;
    logic               valid_r;
    logic               busy_r;

    logic [SW-1:0]      shamt_s;
    logic [WIDTH-1:0]   base_res_s;
    logic               m_sel_s;
    logic               a_signed_s;
    logic               b_signed_s;
    logic               sa_s;
    logic               sb_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic               neg_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_tmp_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   fix_res_s;

    assign shamt_s = opr_2[SW-1:0];
    assign m_sel_s = alu_op[3] && (MUL_EN != 0);

    // Single-cycle base ALU; flag only matters for funct3 000 and 101.
    always_comb begin
        base_res_s = {WIDTH{1'b0}};
        case (alu_op[2:0])
            3'b000: begin
                if (flag) begin
                    base_res_s = opr_1 - opr_2;
                end else begin
                    base_res_s = opr_1 + opr_2;
                end
            end
            3'b001: base_res_s = opr_1 << shamt_s;
            3'b010: base_res_s = {{(WIDTH-1){1'b0}}, ($signed(opr_1) < $signed(opr_2))};
            3'b011: base_res_s = {{(WIDTH-1){1'b0}}, (opr_1 < opr_2)};
            3'b100: base_res_s = opr_1 ^ opr_2;
            3'b101: begin
                if (flag) begin
                    base_res_s = WIDTH'($signed(opr_1) >>> shamt_s);
                end else begin
                    base_res_s = opr_1 >> shamt_s;
                end
            end
            3'b110: base_res_s = opr_1 | opr_2;
            3'b111: base_res_s = opr_1 & opr_2;
            default: base_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Operand signedness and magnitudes for an M op about to be accepted.
    // MUL low half is sign-agnostic, so it is treated as unsigned.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (alu_op[2:0])
            3'b001:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'b010:  begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            3'b100:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'b110:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default: begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
        sa_s    = a_signed_s & opr_1[WIDTH-1];
        sb_s    = b_signed_s & opr_2[WIDTH-1];
        a_mag_s = sa_s ? neg_w(opr_1) : opr_1;
        b_mag_s = sb_s ? neg_w(opr_2) : opr_2;
        // Remainder takes the dividend sign only; everything else is sa^sb.
        if (alu_op[2:0] == 3'b110) begin
            neg_s = sa_s;
        end else begin
            neg_s = sa_s ^ sb_s;
        end
    end

    // One multiply or divide iteration on the shared accumulator.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                     (acc_r[0] ? {1'b0, b_mag_r} : {(WIDTH+1){1'b0}});
        div_tmp_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_ge_s   = (div_tmp_s >= {1'b0, b_mag_r});
        // Remainder stays below the divisor, so the difference fits WIDTH bits.
        div_diff_s = div_tmp_s[WIDTH-1:0] - b_mag_r;
        if (op_r[2]) begin
            acc_next_s = {(div_ge_s ? div_diff_s : div_tmp_s[WIDTH-1:0]),
                          acc_r[WIDTH-2:0], div_ge_s};
        end else begin
            acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Final sign correction and half/quotient/remainder selection.
    always_comb begin
        prod_fix_s = neg_r ? neg_2w(acc_r) : acc_r;
        fix_res_s  = {WIDTH{1'b0}};
        case (op_r)
            3'b000: fix_res_s = prod_fix_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: begin
                if (div_zero_r) begin
                    fix_res_s = {WIDTH{1'b1}};
                end else if (neg_r) begin
                    fix_res_s = neg_w(acc_r[WIDTH-1:0]);
                end else begin
                    fix_res_s = acc_r[WIDTH-1:0];
                end
            end
            // A zero divisor leaves |opr_1| here with the dividend sign,
            // which restores opr_1 exactly.
            3'b110, 3'b111: begin
                if (neg_r) begin
                    fix_res_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
                end else begin
                    fix_res_s = acc_r[2*WIDTH-1:WIDTH];
                end
            end
            default: fix_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM, operand latching, iteration and result register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            op_r       <= 3'b000;
            neg_r      <= 1'b0;
            div_zero_r <= 1'b0;
            b_mag_r    <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            result_r   <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i && m_sel_s) begin
                        op_r       <= alu_op[2:0];
                        neg_r      <= neg_s;
                        div_zero_r <= (opr_2 == {WIDTH{1'b0}});
                        b_mag_r    <= b_mag_s;
                        acc_r      <= {{WIDTH{1'b0}}, a_mag_s};
                        cnt_r      <= {CW{1'b0}};
                        busy_r     <= 1'b1;
                        valid_r    <= 1'b0;
                        state_r    <= ST_CALC;
                    end else if (start_i) begin
                        // With MUL_EN=0 an M op lands here and yields zero.
                        result_r <= alu_op[3] ? {WIDTH{1'b0}} : base_res_s;
                        valid_r  <= 1'b1;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                ST_CALC: begin
                    valid_r <= 1'b0;
                    acc_r   <= acc_next_s;
                    cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_FIX: begin
                    result_r <= fix_res_s;
                    valid_r  <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = result_r;
    assign valid_o  = valid_r;
    assign busy_o   = busy_r;

endmodule
